rx_link_sync_ctrl: RTL and testbench
====================================

Name: rx_link_sync_ctrl

Overview:
Link synchronisation controller for the 8b/10b receive path. Sits between the comma detector/decoder and the RX FIFO. It sequences comma realignment (hunt / verify / locked) and enforces the packet framing of one comma per PKT_SYMS symbols. It gates decoded bytes into the FIFO only while the link is locked, and counts bytes dropped on FIFO full.

Parameters:
PKT_SYMS, 8, symbols per packet including the leading comma; power of 2, >=2
COMMA_BYTE, 8'hBC, decoded K-character value treated as comma (K28.5)
LOCK_COMMAS, 3, consecutive correctly placed commas required to declare lock
LOSS_ERRS, 4, error count that drops lock
GOOD_RUN, 16, consecutive good symbols that decrement the error count by 1

Ports:
clk  in  1  rx clock
rst  in  1  synchronous, active-high reset
sym_valid  in  1  one-cycle pulse: decoder output below valid (one per 10 bits)
sym_data  in  8  decoded byte
sym_k  in  1  decoded symbol is a K-character
code_err  in  1  invalid 10b code, qualified by sym_valid
disp_err  in  1  running-disparity error, qualified by sym_valid
realign_en  out  1  1 = comma detector may re-phase its bit counter on any comma
link_up  out  1  1 while in LOCKED
fifo_full  in  1  RX FIFO full
fifo_wen  out  1  FIFO write strobe
fifo_din  out  8  FIFO write data
drop_cnt  out  16  saturating count of data bytes dropped due to fifo_full in LOCKED
err_cnt  out  3  current error count (debug)

Behaviour:
- Definitions, evaluated only on sym_valid cycles:
  - comma = sym_k && sym_data==COMMA_BYTE.
  - bad = code_err || disp_err || (comma && slot!=0) || (!comma && slot==0) || (sym_k && !comma).
- slot counter: clog2(PKT_SYMS) bits. Increments on each sym_valid and wraps PKT_SYMS-1 -> 0. The increment occurs in all states. Exception: a comma accepted in HUNT forces slot to 1 on the next cycle, because the comma itself occupies slot 0.
- States: HUNT, VERIFY, LOCKED. Reset -> HUNT.
- Reset values: realign_en=1, link_up=0, fifo_wen=0, fifo_din=0, drop_cnt=0, err_cnt=0, slot=0, good_run=0, comma count=0.
- HUNT:
  - realign_en=1.
  - Non-comma symbols are ignored.
  - A comma without code_err/disp_err -> VERIFY with comma count=1.
- VERIFY:
  - realign_en=0.
  - A bad symbol -> HUNT; comma count cleared.
  - A good comma at slot 0 increments the comma count. When the count reaches LOCK_COMMAS -> LOCKED, with err_cnt=0 and good_run=0.
  - LOCK_COMMAS=1 means the HUNT comma alone locks (HUNT -> LOCKED directly).
- LOCKED:
  - link_up=1, realign_en=0.
  - Bad symbol: err_cnt+1 and good_run=0. If err_cnt+1 == LOSS_ERRS -> HUNT. The symbol is not written.
  - Good symbol: good_run+1. When good_run reaches GOOD_RUN and err_cnt>0: err_cnt-1 and good_run=0. If err_cnt==0, good_run saturates.
  - Good non-K data symbol at slot!=0: if !fifo_full, fifo_wen=1 and fifo_din=sym_data on the next cycle (latency 1, registered). If fifo_full, no write and drop_cnt+1, saturating at 16'hFFFF.
  - Commas are never written.
- Outputs change only on the clock edge after the qualifying sym_valid:
  - link_up/realign_en change on the cycle the state changes.
  - fifo_wen is a single-cycle pulse per accepted byte.
- fifo_din holds its last value when fifo_wen=0.
- Symbols while sym_valid=0 are ignored. fifo_full is sampled on the same cycle as sym_valid.
- Exit from LOCKED clears err_cnt and good_run. drop_cnt persists until rst.
- rst mid-operation: all state returns to reset values on the next edge. Any fifo_wen pulse in flight is suppressed (fifo_wen=0 after reset edge).
- Simultaneous events:
  - code_err on a correctly placed comma counts as bad.
  - The error that reaches LOSS_ERRS wins over any write.

Test Plan:
1. Reset, then stream comma + 7 data (0x01..0x07) x4 -> realign_en falls after 1st comma; link_up rises 1 cycle after 3rd comma; bytes 0x01..0x07 of packets 3 and 4 written (14 fifo_wen pulses), commas never written.
2. Locked link, inject code_err on 4 symbols within 16 -> err_cnt 1,2,3 then HUNT on 4th; link_up=0, realign_en=1 next cycle; no write for errored bytes.
3. Locked link, 3 errors each separated by 16 good symbols -> err_cnt returns to 0, link stays up.
4. Locked, fifo_full held high for 5 data symbols -> no fifo_wen, drop_cnt=5; deassert -> writes resume next data symbol.
5. In VERIFY, comma arrives at slot 3 -> HUNT; that same misplaced comma is not taken as a hunt comma; the next comma restarts VERIFY count=1.
6. rst asserted the cycle after a data sym_valid in LOCKED -> fifo_wen=0, link_up=0, drop_cnt=0, state HUNT.

Source files
------------

// File: rtl/rx_link_sync_ctrl.sv
// rx_link_sync_ctrl: 8b/10b comma alignment (hunt/verify/locked), packet framing check and FIFO write gating.
module rx_link_sync_ctrl #(
  parameter int         PKT_SYMS    = 8,
  parameter logic [7:0] COMMA_BYTE  = 8'hBC,
  parameter int         LOCK_COMMAS = 3,
  parameter int         LOSS_ERRS   = 4,
  parameter int         GOOD_RUN    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sym_valid,
  input  logic [7:0]  sym_data,
  input  logic        sym_k,
  input  logic        code_err,
  input  logic        disp_err,
  output logic        realign_en,
  output logic        link_up,
  input  logic        fifo_full,
  output logic        fifo_wen,
  output logic [7:0]  fifo_din,
  output logic [15:0] drop_cnt,
  output logic [2:0]  err_cnt
);
  localparam int SW = $clog2(PKT_SYMS);
  localparam int CW = $clog2(LOCK_COMMAS + 1);
  localparam int GW = $clog2(GOOD_RUN + 1);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  state_t        state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [CW-1:0] ccnt_q, ccnt_d;
  logic [GW-1:0] run_q, run_d;
  logic [2:0]    err_q, err_d;
  logic [15:0]   drop_q, drop_d;
  logic [7:0]    din_q, din_d;
  logic          wen_q, wen_d;
  logic          comma, sym_err, slot0, bad;
  assign comma   = sym_k && sym_data == COMMA_BYTE;
  assign sym_err = code_err || disp_err;
  assign slot0   = slot_q == '0;
  // a comma belongs exactly at slot 0, and any other K-character is illegal
  assign bad     = sym_err || (comma != slot0) || (sym_k && !comma);
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    ccnt_d  = ccnt_q;
    run_d   = run_q;
    err_d   = err_q;
    drop_d  = drop_q;
    din_d   = din_q;
    wen_d   = 1'b0;
    if (sym_valid) begin
      slot_d = slot_q + 1'b1;
      case (state_q)
        HUNT: if (comma && !sym_err) begin
          slot_d  = SW'(1);
          ccnt_d  = CW'(1);
          err_d   = '0;
          run_d   = '0;
          state_d = (LOCK_COMMAS == 1) ? LOCKED : VERIFY;
        end
        VERIFY: if (bad) begin
          state_d = HUNT;
          ccnt_d  = '0;
        end else if (comma) begin
          ccnt_d  = ccnt_q + 1'b1;
          state_d = (ccnt_d == CW'(LOCK_COMMAS)) ? LOCKED : VERIFY;
          err_d   = '0;
          run_d   = '0;
        end
        LOCKED: if (bad) begin
          run_d = '0;
          err_d = err_q + 1'b1;
          if (err_d == 3'(LOSS_ERRS)) begin
            state_d = HUNT;
            err_d   = '0;
            ccnt_d  = '0;
          end
        end else begin
          run_d = (run_q == GW'(GOOD_RUN)) ? run_q : run_q + 1'b1;
          if (run_d == GW'(GOOD_RUN) && err_q != '0) begin
            err_d = err_q - 1'b1;
            run_d = '0;
          end
          if (!comma) begin
            wen_d  = !fifo_full;
            din_d  = fifo_full ? din_q : sym_data;
            drop_d = (fifo_full && !(&drop_q)) ? drop_q + 1'b1 : drop_q;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= '0;
      ccnt_q  <= '0;
      run_q   <= '0;
      err_q   <= '0;
      drop_q  <= '0;
      din_q   <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      ccnt_q  <= ccnt_d;
      run_q   <= run_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      din_q   <= din_d;
      wen_q   <= wen_d;
    end
  end
  assign realign_en = state_q == HUNT;
  assign link_up    = state_q == LOCKED;
  assign fifo_wen   = wen_q;
  assign fifo_din   = din_q;
  assign drop_cnt   = drop_q;
  assign err_cnt    = err_q;
endmodule

// File: tb/tb_rx_link_sync_ctrl.sv
// tb_rx_link_sync_ctrl: table-driven, directed and randomized checks against a behavioural link model.
module tb_rx_link_sync_ctrl;
  localparam int PKT = 8;
  localparam int LOCKN = 3;
  localparam int LOSS = 4;
  localparam int GOOD = 16;
  logic clk = 0, rst = 1;
  logic sym_valid = 0, sym_k = 0, code_err = 0, disp_err = 0, fifo_full = 0;
  logic [7:0] sym_data = 0;
  logic realign_en, link_up, fifo_wen;
  logic [7:0] fifo_din;
  logic [15:0] drop_cnt;
  logic [2:0] err_cnt;
  int checks = 0, errors = 0;
  rx_link_sync_ctrl dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_data(sym_data), .sym_k(sym_k),
    .code_err(code_err), .disp_err(disp_err), .realign_en(realign_en), .link_up(link_up),
    .fifo_full(fifo_full), .fifo_wen(fifo_wen), .fifo_din(fifo_din), .drop_cnt(drop_cnt),
    .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  // behavioural model: mode 0 hunting, 1 verifying, 2 locked
  int m_mode, m_slot, m_commas, m_errs, m_run, m_drop;
  logic m_wen;
  logic [7:0] m_din;
  task automatic model_reset();
    m_mode = 0; m_slot = 0; m_commas = 0; m_errs = 0; m_run = 0; m_drop = 0;
    m_wen = 0; m_din = 0;
  endtask
  task automatic model_step(input logic v, input logic [7:0] d, input logic k, ce, de, ff);
    bit is_comma, errored, bad;
    int nslot;
    m_wen = 0;
    if (!v) return;
    is_comma = k && d == 8'hBC;
    errored = ce || de;
    bad = errored || (is_comma && m_slot != 0) || (!is_comma && m_slot == 0) || (k && !is_comma);
    nslot = (m_slot + 1) % PKT;
    if (m_mode == 0) begin
      if (is_comma && !errored) begin
        nslot = 1; m_commas = 1; m_errs = 0; m_run = 0;
        m_mode = (LOCKN == 1) ? 2 : 1;
      end
    end else if (m_mode == 1) begin
      if (bad) begin m_mode = 0; m_commas = 0; end
      else if (is_comma) begin
        m_commas++;
        if (m_commas == LOCKN) begin m_mode = 2; m_errs = 0; m_run = 0; end
      end
    end else begin
      if (bad) begin
        m_errs++; m_run = 0;
        if (m_errs == LOSS) begin m_mode = 0; m_errs = 0; m_commas = 0; end
      end else begin
        m_run = (m_run < GOOD) ? m_run + 1 : GOOD;
        if (m_run == GOOD && m_errs > 0) begin m_errs--; m_run = 0; end
        if (!is_comma) begin
          if (ff) m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
          else begin m_wen = 1; m_din = d; end
        end
      end
    end
    m_slot = nslot;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic compare_all();
    chk("link_up", 32'(link_up), 32'(m_mode == 2));
    chk("realign_en", 32'(realign_en), 32'(m_mode == 0));
    chk("fifo_wen", 32'(fifo_wen), 32'(m_wen));
    chk("fifo_din", 32'(fifo_din), 32'(m_din));
    chk("err_cnt", 32'(err_cnt), 32'(m_errs));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask
  task automatic step(input logic v, input logic [7:0] d, input logic k, ce, de, ff);
    sym_valid = v; sym_data = d; sym_k = k; code_err = ce; disp_err = de; fifo_full = ff;
    @(posedge clk);
    #1;
    model_step(v, d, k, ce, de, ff);
    compare_all();
    sym_valid = 0; code_err = 0; disp_err = 0;
  endtask
  task automatic good_sym(input logic ff);
    if (m_slot == 0) step(1, 8'hBC, 1, 0, 0, ff);
    else step(1, 8'($urandom_range(0, 255)), 0, 0, 0, ff);
  endtask
  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    compare_all();
  endtask
  task automatic lock_link();
    step(1, 8'hBC, 1, 0, 0, 0);
    for (int i = 0; i < 40 && m_mode != 2; i++) good_sym(0);
    chk("lock_link", 32'(link_up), 32'd1);
  endtask
  typedef struct {
    logic v; logic [7:0] d; logic k; logic ce, de, ff;
    logic exp_wen; logic [7:0] exp_din; logic exp_link, exp_realign;
  } vec_t;
  vec_t tbl[32];
  int wens;
  initial begin
    for (int i = 0; i < 32; i++) begin
      int p, s;
      p = i / 8; s = i % 8;
      tbl[i].v = 1; tbl[i].k = (s == 0); tbl[i].d = (s == 0) ? 8'hBC : 8'(s);
      tbl[i].ce = 0; tbl[i].de = 0; tbl[i].ff = 0;
      tbl[i].exp_wen = (p >= 2 && s != 0);
      tbl[i].exp_din = (p >= 2 && s != 0) ? 8'(s) : ((p == 3) ? 8'h07 : 8'h00);
      tbl[i].exp_link = (p >= 2);
      tbl[i].exp_realign = 0;
    end
    // reset state
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare_all();
    chk("rst_realign", 32'(realign_en), 32'd1);
    rst = 0;
    // 1: four packets, lock on 3rd comma
    wens = 0;
    for (int i = 0; i < 32; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].k, tbl[i].ce, tbl[i].de, tbl[i].ff);
      chk("t1_wen", 32'(fifo_wen), 32'(tbl[i].exp_wen));
      if (tbl[i].exp_wen) chk("t1_din", 32'(fifo_din), 32'(tbl[i].exp_din));
      chk("t1_link", 32'(link_up), 32'(tbl[i].exp_link));
      chk("t1_realign", 32'(realign_en), 32'(tbl[i].exp_realign));
      wens += int'(fifo_wen);
    end
    chk("t1_wen_count", 32'(wens), 32'd14);
    // 2: four code errors within 16 symbols drop lock
    for (int e = 1; e <= 4; e++) begin
      step(1, 8'h55, 0, 1, 0, 0);
      chk("t2_no_write", 32'(fifo_wen), 32'd0);
      if (e < 4) begin
        chk("t2_err_cnt", 32'(err_cnt), 32'(e));
        chk("t2_link_held", 32'(link_up), 32'd1);
        good_sym(0);
      end
    end
    chk("t2_link_down", 32'(link_up), 32'd0);
    chk("t2_realign", 32'(realign_en), 32'd1);
    chk("t2_err_clr", 32'(err_cnt), 32'd0);
    // 5: misplaced comma in VERIFY returns to HUNT and is not a hunt comma
    step(1, 8'hBC, 1, 0, 0, 0);
    chk("t5_verify", 32'(realign_en), 32'd0);
    step(1, 8'h11, 0, 0, 0, 0);
    step(1, 8'h12, 0, 0, 0, 0);
    step(1, 8'hBC, 1, 0, 0, 0);
    chk("t5_hunt", 32'(realign_en), 32'd1);
    step(1, 8'h14, 0, 0, 0, 0);
    chk("t5_still_hunt", 32'(realign_en), 32'd1);
    step(1, 8'hBC, 1, 0, 0, 0);
    chk("t5_restart", 32'(realign_en), 32'd0);
    for (int i = 0; i < 16; i++) begin
      good_sym(0);
      if (i == 7) chk("t5_count2", 32'(link_up), 32'd0);
      if (i == 15) chk("t5_count3", 32'(link_up), 32'd1);
    end
    // 3: isolated errors healed by 16 good symbols
    for (int e = 0; e < 3; e++) begin
      step(1, 8'h33, 0, 1, 0, 0);
      chk("t3_err_up", 32'(err_cnt), 32'd1);
      for (int i = 0; i < 16; i++) good_sym(0);
      chk("t3_err_heal", 32'(err_cnt), 32'd0);
    end
    chk("t3_link", 32'(link_up), 32'd1);
    // 4: FIFO full drops five data bytes
    for (int sent = 0; sent < 5;) begin
      if (m_slot == 0) good_sym(1);
      else begin
        step(1, 8'(8'h60 + sent), 0, 0, 0, 1);
        chk("t4_no_write", 32'(fifo_wen), 32'd0);
        sent++;
      end
    end
    chk("t4_drop", 32'(drop_cnt), 32'd5);
    if (m_slot == 0) good_sym(0);
    step(1, 8'hA5, 0, 0, 0, 0);
    chk("t4_resume_wen", 32'(fifo_wen), 32'd1);
    chk("t4_resume_din", 32'(fifo_din), 32'hA5);
    // 6: reset while a write is due
    if (m_slot == 0) good_sym(0);
    step(1, 8'h77, 0, 0, 0, 0);
    chk("t6_pre_wen", 32'(fifo_wen), 32'd1);
    sym_valid = 1; sym_data = 8'h78; sym_k = 0; fifo_full = 0; rst = 1;
    @(posedge clk);
    #1;
    rst = 0; sym_valid = 0;
    model_reset();
    chk("t6_wen", 32'(fifo_wen), 32'd0);
    chk("t6_link", 32'(link_up), 32'd0);
    chk("t6_drop", 32'(drop_cnt), 32'd0);
    chk("t6_realign", 32'(realign_en), 32'd1);
    compare_all();
    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      int r;
      logic v, k, ce, de, ff;
      logic [7:0] d;
      r = $urandom_range(0, 99);
      v = $urandom_range(0, 9) != 0;
      k = (m_slot == 0); d = k ? 8'hBC : 8'($urandom_range(0, 255));
      ce = 0; de = 0;
      ff = $urandom_range(0, 4) == 0;
      if (r < 3) ce = 1;
      else if (r < 5) de = 1;
      else if (r < 7) begin k = !k; d = k ? 8'hBC : 8'h42; end
      else if (r < 8) begin k = 1; d = 8'h1C; end
      if ($urandom_range(0, 999) == 0) do_reset();
      else step(v, d, k, ce, de, ff);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
